// File: rtl/synth_pkg.sv
// Shared widths and scheduler state encoding for the synth voice bank.
package synth_pkg;

  localparam int unsigned TONE_W = 10;
  localparam int unsigned AMP_W  = 8;
  localparam int unsigned AGE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY
  } sched_state_t;

endpackage

// File: rtl/step_timer.sv
// Free-running sample-strobe generator: one-cycle pulse every STEP_PERIOD clocks.
module step_timer #(
  parameter int unsigned STEP_PERIOD = 8333
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic step_out
);

  localparam int unsigned CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign step_out = (cnt == LAST) && !rst_in;

  // Count 0..STEP_PERIOD-1 and wrap on the strobe cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Allocates note-on/off events across a bank of sawtooth voices and mixes
// the amplitudes of active voices once per sample strobe.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned STEP_PERIOD = 8333
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   note_valid_in,
  output logic                                   note_ready_out,
  input  logic                                   note_on_in,
  input  logic [TONE_W-1:0]                      note_tone_in,
  input  logic [NUM_VOICES*AMP_W-1:0]            voice_amp_in,
  output logic                                   step_out,
  output logic [NUM_VOICES*TONE_W-1:0]           voice_tone_out,
  output logic [NUM_VOICES-1:0]                  voice_active_out,
  output logic [NUM_VOICES-1:0]                  voice_rst_out,
  output logic signed [AMP_W+$clog2(NUM_VOICES)-1:0] mix_out
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned MIX_W = AMP_W + $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  sched_state_t state, state_nx;

  logic                           accept;
  logic                           ev_on;
  logic [TONE_W-1:0]              ev_tone;
  logic [IDX_W-1:0]               scan_idx;
  logic                           match_found;
  logic [IDX_W-1:0]               match_idx;
  logic                           free_found;
  logic [IDX_W-1:0]               free_idx;
  logic [IDX_W-1:0]               old_idx;
  logic [AGE_W-1:0]               old_age;
  logic [IDX_W-1:0]               chosen;

  logic [NUM_VOICES*TONE_W-1:0]   tone_q;
  logic [NUM_VOICES-1:0]          active_q;
  logic [NUM_VOICES*AGE_W-1:0]    age_q;
  logic [NUM_VOICES-1:0]          vrst_q;
  logic signed [MIX_W-1:0]        mix_q;
  logic signed [MIX_W-1:0]        mix_sum;

  logic [TONE_W-1:0]              cur_tone;
  logic [AGE_W-1:0]               cur_age;
  logic                           cur_active;

  assign accept           = note_valid_in && note_ready_out;
  assign voice_tone_out   = tone_q;
  assign voice_active_out = active_q;
  assign voice_rst_out    = vrst_q;
  assign mix_out          = mix_q;

  step_timer #(
    .STEP_PERIOD(STEP_PERIOD)
  ) u_step_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .step_out(step_out)
  );

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state: accept -> scan every voice -> apply for one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_nx = APPLY;
      APPLY:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: events are only taken while idle and out of reset.
  always_comb begin
    note_ready_out = (state == IDLE) && !rst_in;
  end

  // Per-voice fields for the voice currently under scan.
  always_comb begin
    cur_tone   = tone_q[scan_idx*TONE_W +: TONE_W];
    cur_age    = age_q[scan_idx*AGE_W +: AGE_W];
    cur_active = active_q[scan_idx];
  end

  // Allocation priority: retrigger a matching voice, else first free, else oldest.
  always_comb begin
    if (match_found) begin
      chosen = match_idx;
    end else if (free_found) begin
      chosen = free_idx;
    end else begin
      chosen = old_idx;
    end
  end

  // Event latch, candidate scan and voice-table update.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ev_on       <= 1'b0;
      ev_tone     <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      tone_q      <= '0;
      active_q    <= '0;
      age_q       <= '0;
      vrst_q      <= '0;
    end else begin
      vrst_q <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            ev_on       <= note_on_in;
            ev_tone     <= note_tone_in;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
          end
        end
        SCAN: begin
          // Only the first hit is kept so ties resolve to the lowest index.
          if (cur_active && (cur_tone == ev_tone) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!cur_active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (cur_age > old_age) begin
            old_age <= cur_age;
            old_idx <= scan_idx;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        APPLY: begin
          if (ev_on) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == chosen) begin
                tone_q[i*TONE_W +: TONE_W] <= ev_tone;
                active_q[i]                <= 1'b1;
                age_q[i*AGE_W +: AGE_W]    <= '0;
                vrst_q[i]                  <= 1'b1;
              end else if (active_q[i] && (age_q[i*AGE_W +: AGE_W] != AGE_MAX)) begin
                age_q[i*AGE_W +: AGE_W] <= age_q[i*AGE_W +: AGE_W] + 1'b1;
              end
            end
          end else if (match_found) begin
            active_q[match_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sign-extended sum of active voice amplitudes.
  always_comb begin
    mix_sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (active_q[i]) begin
        mix_sum = mix_sum + MIX_W'($signed(voice_amp_in[i*AMP_W +: AMP_W]));
      end
    end
  end

  // Capture the mix on each sample strobe (uses the pre-update active set).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mix_q <= '0;
    end else if (step_out) begin
      mix_q <= mix_sum;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed, table-driven bench for voice_scheduler.
module tb_voice_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned SP = 8333;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        note_valid_in;
  logic        note_ready_out;
  logic        note_on_in;
  logic [9:0]  note_tone_in;
  logic [31:0] voice_amp_in;
  logic        step_out;
  logic [39:0] voice_tone_out;
  logic [3:0]  voice_active_out;
  logic [3:0]  voice_rst_out;
  logic signed [9:0] mix_out;

  int n_pass  = 0;
  int n_total = 0;

  voice_scheduler #(
    .NUM_VOICES (N),
    .STEP_PERIOD(SP)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .note_valid_in   (note_valid_in),
    .note_ready_out  (note_ready_out),
    .note_on_in      (note_on_in),
    .note_tone_in    (note_tone_in),
    .voice_amp_in    (voice_amp_in),
    .step_out        (step_out),
    .voice_tone_out  (voice_tone_out),
    .voice_active_out(voice_active_out),
    .voice_rst_out   (voice_rst_out),
    .mix_out         (mix_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        on;
    logic [9:0]  tone;
    logic [3:0]  act;
    logic [3:0]  vrst;
    logic [39:0] tones;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in        = 1'b1;
    note_valid_in = 1'b0;
    tick();
    tick();
    chk("ready_in_reset", {63'b0, note_ready_out}, 64'd0);
    rst_in = 1'b0;
    #1;
    chk("ready_after_reset", {63'b0, note_ready_out}, 64'd1);
  endtask

  // Issue one event, then check busy state at NUM_VOICES+1 and results at NUM_VOICES+2.
  task automatic do_event(input string name, input logic on, input logic [9:0] tone,
                          input logic [3:0] exp_act, input logic [3:0] exp_rst,
                          input logic [39:0] exp_tones);
    for (int k = 0; k < 32 && !note_ready_out; k++) tick();
    chk({name, "_ready_wait"}, {63'b0, note_ready_out}, 64'd1);
    note_valid_in = 1'b1;
    note_on_in    = on;
    note_tone_in  = tone;
    tick();
    note_valid_in = 1'b0;
    for (int k = 1; k < N + 1; k++) tick();
    chk({name, "_busy"}, {59'b0, note_ready_out, voice_rst_out}, 64'd0);
    tick();
    chk({name, "_ready"}, {63'b0, note_ready_out}, 64'd1);
    chk({name, "_active"}, {60'b0, voice_active_out}, {60'b0, exp_act});
    chk({name, "_vrst"}, {60'b0, voice_rst_out}, {60'b0, exp_rst});
    chk({name, "_tones"}, {24'b0, voice_tone_out}, {24'b0, exp_tones});
  endtask

  task automatic wait_step(input string name);
    int k;
    for (k = 0; k < int'(SP) + 4 && !step_out; k++) tick();
    chk({name, "_step_seen"}, {63'b0, step_out}, 64'd1);
  endtask

  initial begin
    int pulses[$];
    logic bad;

    tbl[0] = '{1'b1, 10'd100, 4'b0001, 4'b0001, {10'd0,   10'd0,   10'd0,   10'd100}};
    tbl[1] = '{1'b1, 10'd200, 4'b0011, 4'b0010, {10'd0,   10'd0,   10'd200, 10'd100}};
    tbl[2] = '{1'b1, 10'd300, 4'b0111, 4'b0100, {10'd0,   10'd300, 10'd200, 10'd100}};
    tbl[3] = '{1'b1, 10'd400, 4'b1111, 4'b1000, {10'd400, 10'd300, 10'd200, 10'd100}};
    tbl[4] = '{1'b1, 10'd500, 4'b1111, 4'b0001, {10'd400, 10'd300, 10'd200, 10'd500}};
    tbl[5] = '{1'b1, 10'd300, 4'b1111, 4'b0100, {10'd400, 10'd300, 10'd200, 10'd500}};
    tbl[6] = '{1'b0, 10'd999, 4'b1111, 4'b0000, {10'd400, 10'd300, 10'd200, 10'd500}};
    tbl[7] = '{1'b0, 10'd200, 4'b1101, 4'b0000, {10'd400, 10'd300, 10'd200, 10'd500}};
    tbl[8] = '{1'b1, 10'd600, 4'b1111, 4'b0010, {10'd400, 10'd300, 10'd600, 10'd500}};
    tbl[9] = '{1'b1, 10'd700, 4'b1111, 4'b1000, {10'd700, 10'd300, 10'd600, 10'd500}};

    rst_in        = 1'b1;
    note_valid_in = 1'b0;
    note_on_in    = 1'b0;
    note_tone_in  = '0;
    voice_amp_in  = '0;

    // Idle timing: strobes at 8332, 16665, 24998 counted from the first post-reset cycle.
    do_reset();
    bad = 1'b0;
    for (int c = 0; c < 3 * int'(SP); c++) begin
      if (step_out) pulses.push_back(c);
      if (voice_tone_out != '0 || voice_active_out != '0 || voice_rst_out != '0 ||
          mix_out != '0 || !note_ready_out) bad = 1'b1;
      tick();
    end
    chk("idle_outputs_zero", {63'b0, bad}, 64'd0);
    chk("step_pulse_count", 64'(pulses.size()), 64'd3);
    if (pulses.size() >= 3) begin
      chk("step_pulse0", 64'(pulses[0]), 64'd8332);
      chk("step_pulse1", 64'(pulses[1]), 64'd16665);
      chk("step_pulse2", 64'(pulses[2]), 64'd24998);
    end

    // Allocation table: fill, steal oldest, retrigger, drop, release, reuse, steal again.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_event($sformatf("vec%0d", i), tbl[i].on, tbl[i].tone, tbl[i].act, tbl[i].vrst, tbl[i].tones);
    end

    // Note-off with no match is dropped; matching note-off keeps tone.
    do_reset();
    do_event("on7",   1'b1, 10'd7, 4'b0001, 4'b0001, {10'd0, 10'd0, 10'd0, 10'd7});
    do_event("off9",  1'b0, 10'd9, 4'b0001, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd7});
    do_event("off7",  1'b0, 10'd7, 4'b0000, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd7});

    // Mix: voices 0 and 2 active, amps +100, -30, +127, -128 -> 227.
    do_reset();
    do_event("m_on7",  1'b1, 10'd7, 4'b0001, 4'b0001, {10'd0, 10'd0, 10'd0, 10'd7});
    do_event("m_on8",  1'b1, 10'd8, 4'b0011, 4'b0010, {10'd0, 10'd0, 10'd8, 10'd7});
    do_event("m_on9",  1'b1, 10'd9, 4'b0111, 4'b0100, {10'd0, 10'd9, 10'd8, 10'd7});
    do_event("m_off8", 1'b0, 10'd8, 4'b0101, 4'b0000, {10'd0, 10'd9, 10'd8, 10'd7});
    voice_amp_in = {8'h80, 8'h7F, 8'hE2, 8'h64};
    wait_step("mix1");
    chk("mix_before_update", {54'b0, mix_out}, 64'd0);
    tick();
    chk("mix_227", {54'b0, mix_out}, 64'd227);
    do_event("m_on10", 1'b1, 10'd10, 4'b0111, 4'b0010, {10'd0, 10'd9, 10'd10, 10'd7});
    chk("mix_holds", {54'b0, mix_out}, 64'd227);
    wait_step("mix2");
    tick();
    chk("mix_197", {54'b0, mix_out}, 64'd197);

    // Reset during SCAN abandons the event.
    do_reset();
    voice_amp_in  = '0;
    note_valid_in = 1'b1;
    note_on_in    = 1'b1;
    note_tone_in  = 10'd55;
    tick();
    note_valid_in = 1'b0;
    tick();
    chk("scan_busy", {63'b0, note_ready_out}, 64'd0);
    rst_in = 1'b1;
    #1;
    chk("ready_low_in_reset", {63'b0, note_ready_out}, 64'd0);
    tick();
    chk("rst_mid_active", {60'b0, voice_active_out}, 64'd0);
    chk("rst_mid_vrst", {60'b0, voice_rst_out}, 64'd0);
    chk("rst_mid_tones", {24'b0, voice_tone_out}, 64'd0);
    chk("rst_mid_mix", {54'b0, mix_out}, 64'd0);
    rst_in = 1'b0;
    #1;
    chk("rst_mid_ready", {63'b0, note_ready_out}, 64'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("rst_mid_never_applied", {56'b0, voice_active_out, voice_rst_out}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Allocates incoming note-on/note-off events across a fixed bank of `sawtooth_generator` voices. Drives each voice's `tone_in` and phase reset, and issues the shared `step_in` sample strobe. Sums the amplitudes of the active voices into one mixed sample. It sits between the note source (keyboard/MIDI decoder) and the audio output path.

## Interface
- `NUM_VOICES`, default 4: number of generator instances managed.
- `STEP_PERIOD`, default 8333: clk_in cycles per sample strobe (100 MHz / 12 kHz).
- `clk_in`  input  1  system clock; all logic is clocked on its rising edge.
- `rst_in`  input  1  reset, synchronous, active-high.
- `note_valid_in`  input  1  event available.
- `note_ready_out`  output  1  scheduler can accept an event.
- `note_on_in`  input  1  1 = note-on, 0 = note-off.
- `note_tone_in`  input  10  tone index (same encoding as the generator `tone_in`).
- `voice_amp_in`  input  NUM_VOICES×8  signed amplitude from each generator.
- `step_out`  output  1  one-cycle sample strobe to all generators.
- `voice_tone_out`  output  NUM_VOICES×10  tone per voice.
- `voice_active_out`  output  NUM_VOICES  voice gate.
- `voice_rst_out`  output  NUM_VOICES  one-cycle phase-reset pulse on (re)allocation.
- `mix_out`  output  8+$clog2(NUM_VOICES)  signed sum of active voice amplitudes.

## Operation
- **Handshake:** an event is accepted on a cycle where `note_valid_in && note_ready_out`. `note_tone_in` and `note_on_in` are latched on that cycle. `note_ready_out` is high only in IDLE.
- **FSM states:**
  - IDLE: on accept, go to SCAN.
  - SCAN: examines one voice per cycle, index 0..NUM_VOICES-1, recording match, first-free and oldest candidates. After the last index, go to APPLY.
  - APPLY: one cycle, then back to IDLE.
- **Note-on, applied in APPLY:**
  - If an active voice already has the same tone, that voice is retriggered.
  - Otherwise the lowest-index inactive voice is used.
  - Otherwise the voice with the largest age is stolen; ties go to the lowest index.
  - In all three cases the chosen voice gets: tone written, active set, age cleared, `voice_rst_out` pulsed.
- **Note-off:** clears active on the lowest-index active voice with a matching tone. If none matches, the event is silently dropped. Tone is retained.
- **Age:** a per-voice 8-bit counter. Every accepted note-on increments the age of all other active voices, saturating at 255.
- **Step timer:**
  - Free-running counter 0..STEP_PERIOD-1.
  - `step_out` is high on the cycle the counter equals STEP_PERIOD-1; the counter then wraps to 0.
  - The timer is independent of the FSM.
- **Mix:** on each `step_out` cycle, `mix_out` is registered with the sign-extended sum of `voice_amp_in[i]` over voices with active=1. Inactive voices contribute 0. The sum never overflows at the stated width.
- **Reset:**
  - Returns the FSM to IDLE and clears counters.
  - Abandons any in-flight event: it is never applied.

## Timing
- **Reset values:** `note_ready_out`=0 during reset and 1 the cycle after; `step_out`=0; `voice_tone_out`=0; `voice_active_out`=0; `voice_rst_out`=0; `mix_out`=0.
- **Event latency:** accept at cycle 0; SCAN on cycles 1..NUM_VOICES; APPLY on cycle NUM_VOICES+1. Voice outputs and `voice_rst_out` are visible on cycle NUM_VOICES+2.
- **Event rate:** `note_ready_out` returns high at cycle NUM_VOICES+2, giving a maximum of one event per NUM_VOICES+2 cycles.
- **Mix latency:** `mix_out` updates one cycle after `step_out`, using `voice_active_out` and `voice_amp_in` sampled on the `step_out` cycle.
- **APPLY on a step cycle:** if APPLY coincides with `step_out`, the mix uses the pre-APPLY active set.
- **Steady-state step spacing:** the first `step_out` after reset occurs on cycle STEP_PERIOD-1. Every later pulse is exactly STEP_PERIOD cycles apart.
- **Reset mid-event:** `rst_in` asserted during SCAN or APPLY forces the reset values on the next cycle.

## Structure
- **Shared package `synth_pkg`:** `TONE_W`=10, `AMP_W`=8, `AGE_W`=8, and the FSM enum `sched_state_t` {IDLE, SCAN, APPLY}.
- **Sub-module `step_timer`:** holds the counter and strobe, parameterized by STEP_PERIOD. It is reusable by other generator banks.
- **Top level:** the per-voice arrays for tone, active and age are packed vectors in `voice_scheduler`.

## Test plan
- Reset then idle 3×STEP_PERIOD → `step_out` pulses at cycles 8332, 16665, 24998; all other outputs 0.
- Note-on tone 100 then tone 200 → voice0 tone 100 and voice1 tone 200 active; each `voice_rst_out` pulses 6 cycles after its accept.
- Five note-ons with tones 1..5 and NUM_VOICES=4 → tone 5 steals voice0 (oldest); `voice_tone_out[0]`=5 and voices 1..3 are unchanged.
- Note-on tone 7, note-off tone 9, note-off tone 7 → tone 9 is ignored; voice0 becomes inactive after the second off; `note_ready_out` handshakes complete each time.
- Voices 0 and 2 active with amps +100, -30, +127, -128 → `mix_out`=227 the cycle after `step_out`.
- `rst_in` asserted during SCAN of a note-on → no voice is activated; `note_ready_out`=1 the cycle after reset deasserts.
